// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - wait-stated data memory with byte/half/word loads and stores for a stalling CPU.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged instead of aligned down.
module dmem_resp #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  MemRead,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] aluout,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [2:0]    rd_q, rd_d;
    logic [1:0]    wr_q, wr_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH];

    logic          req_present;
    logic [2:0]    in_rd;
    logic          sel_in;
    logic [2:0]    e_rd;
    logic [1:0]    e_wr;
    logic [AW+1:0] e_addr;
    logic [31:0]   e_data;
    logic          is_half, is_word, blocked, commit, mem_we;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlane, rword, shifted, ld_val;

    assign req_present = (MemRead >= 3'd1 && MemRead <= 3'd5) || (MemWrite != 2'b00);
    // A store in the same cycle as a load wins; the load type is dropped at the latch.
    assign in_rd = (MemWrite != 2'b00 || MemRead > 3'd5) ? 3'd0 : MemRead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 3'd0;
            wr_q    <= 2'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_present) begin
                    stall   = 1'b1;
                    rd_d    = in_rd;
                    wr_d    = MemWrite;
                    addr_d  = aluout[AW+1:0];
                    data_d  = WriteData;
                    cnt_d   = WAIT_C;
                    state_d = (WAIT_C != 4'd0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // With WAIT=0 the access completes from IDLE, so the live inputs stand in for the latch.
    assign sel_in = (state_q == IDLE);
    assign e_rd   = sel_in ? in_rd           : rd_q;
    assign e_wr   = sel_in ? MemWrite        : wr_q;
    assign e_addr = sel_in ? aluout[AW+1:0]  : addr_q;
    assign e_data = sel_in ? WriteData       : data_q;

    assign is_half = (e_wr == 2'd2) || (e_rd == 3'd2) || (e_rd == 3'd5);
    assign is_word = (e_wr == 2'd3) || (e_rd == 3'd3);
    assign off     = is_word ? 2'b00 : (is_half ? {e_addr[1], 1'b0} : e_addr[1:0]);
    assign idx     = e_addr[AW+1:2];
    assign commit  = (state_d == DONE) && !rst;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign blocked = (is_half && e_addr[0]) || (is_word && (e_addr[1:0] != 2'b00));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (commit && blocked) begin
            mis_q <= 1'b1;
        end
    end
    assign misalign = mis_q;
`else
    assign blocked  = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        be    = 4'b0000;
        wlane = e_data;
        case (e_wr)
            2'd1: begin
                be    = 4'b0001 << off;
                wlane = {4{e_data[7:0]}};
            end
            2'd2: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{e_data[15:0]}};
            end
            2'd3: begin
                be    = 4'b1111;
                wlane = e_data;
            end
            default: begin
                be    = 4'b0000;
                wlane = e_data;
            end
        endcase
    end

    assign mem_we = commit && (e_wr != 2'b00) && !blocked;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    assign rword   = mem[idx];
    assign shifted = rword >> {off, 3'b000};

    always_comb begin
        ld_val = 32'd0;
        case (e_rd)
            3'd1:    ld_val = {{24{shifted[7]}}, shifted[7:0]};
            3'd2:    ld_val = {{16{shifted[15]}}, shifted[15:0]};
            3'd3:    ld_val = rword;
            3'd4:    ld_val = {24'd0, shifted[7:0]};
            3'd5:    ld_val = {16'd0, shifted[15:0]};
            default: ld_val = 32'd0;
        endcase
        if (blocked) begin
            ld_val = 32'd0;
        end
    end

    assign rdata_d  = (commit && (e_rd != 3'd0)) ? ld_val : rdata_q;
    assign ReadData = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - randomized bench for dmem_resp against a byte-array reference model.
module tb_dmem_resp;

    localparam int DEPTH = 256;
    localparam int WAIT  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] aluout;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        stall;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mb [DEPTH*4];
    logic [31:0] rd_m;
    logic        mis_m;

    dmem_resp #(.DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .aluout    (aluout),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .stall     (stall),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        MemRead   = 3'd0;
        MemWrite  = 2'd0;
        aluout    = 32'd0;
        WriteData = 32'd0;
    endtask

    task automatic model_apply(input logic [2:0] rd, input logic [1:0] wr,
                               input logic [31:0] a, input logic [31:0] d);
        int w, off, sz;
        bit is_wr, is_rd, mis;
        logic [31:0] v;
        is_wr = (wr != 2'd0);
        is_rd = !is_wr && rd >= 3'd1 && rd <= 3'd5;
        if (!is_wr && !is_rd) return;
        if (is_wr) sz = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
        else       sz = (rd == 3'd1 || rd == 3'd4) ? 1 : (rd == 3'd2 || rd == 3'd5) ? 2 : 4;
        w   = int'(a[31:2] % DEPTH);
        off = int'(a[1:0]);
        mis = (off % sz) != 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (mis) begin
            mis_m = 1'b1;
            if (is_rd) rd_m = 32'd0;
            return;
        end
`else
        if (mis) off = off - (off % sz);
`endif
        if (is_wr) begin
            for (int i = 0; i < sz; i++) mb[w*4 + off + i] = d[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[w*4 + off + i];
            if (rd == 3'd1 && v[7])  v = v | 32'hFFFF_FF00;
            if (rd == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
            rd_m = v;
        end
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT back in IDLE.
    task automatic access(input logic [2:0] rd, input logic [1:0] wr,
                          input logic [31:0] a, input logic [31:0] d, input bit scramble);
        int lat;
        bit req;
        req       = (wr != 2'd0) || (rd >= 3'd1 && rd <= 3'd5);
        MemRead   = rd;
        MemWrite  = wr;
        aluout    = a;
        WriteData = d;
        if (!req) begin
            @(negedge clk);
            chk("idle_stall", {31'd0, stall}, 32'd0);
            chk("idle_rdata", ReadData, rd_m);
            @(posedge clk); #1;
            clr();
            return;
        end
        model_apply(rd, wr, a, d);
        lat = 0;
        @(negedge clk);
        while (stall === 1'b1 && lat < 40) begin
            lat++;
            @(posedge clk); #1;
            if (scramble) begin
                MemRead   = 3'($urandom_range(0, 7));
                MemWrite  = 2'($urandom_range(0, 3));
                aluout    = $urandom;
                WriteData = $urandom;
            end
            @(negedge clk);
        end
        chk("latency", lat, WAIT + 1);
        chk("rdata", ReadData, rd_m);
        chk("misalign", {31'd0, misalign}, {31'd0, mis_m});
        clr();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] prior;
        logic [2:0]  r;
        logic [1:0]  wsel;
        clr();
        rd_m  = 32'd0;
        mis_m = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_rdata", ReadData, 32'd0);
        chk("reset_misalign", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int w = 0; w < DEPTH; w++) access(3'd0, 2'd3, 32'(w * 4), $urandom, 1'b0);

        access(3'd0, 2'd3, 32'h10, 32'hDEAD_BEEF, 1'b0);
        access(3'd3, 2'd0, 32'h10, 32'd0, 1'b0);
        chk("lw_10", ReadData, 32'hDEAD_BEEF);
        access(3'd1, 2'd0, 32'h13, 32'd0, 1'b0);
        chk("lb_13", ReadData, 32'hFFFF_FFDE);
        access(3'd4, 2'd0, 32'h13, 32'd0, 1'b0);
        chk("lbu_13", ReadData, 32'h0000_00DE);
        access(3'd2, 2'd0, 32'h12, 32'd0, 1'b0);
        chk("lh_12", ReadData, 32'hFFFF_DEAD);
        access(3'd5, 2'd0, 32'h10, 32'd0, 1'b0);
        chk("lhu_10", ReadData, 32'h0000_BEEF);
        access(3'd0, 2'd1, 32'h11, 32'h5A, 1'b0);
        access(3'd3, 2'd0, 32'h10, 32'd0, 1'b0);
        chk("sb_merge", ReadData, 32'hDEAD_5AEF);

        prior = {mb[32'h23], mb[32'h22], mb[32'h21], mb[32'h20]};
        MemWrite  = 2'd3;
        aluout    = 32'h20;
        WriteData = 32'h1;
        @(negedge clk);
        chk("rst_pre_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_rdata", ReadData, 32'd0);
        chk("rst_mid_misalign", {31'd0, misalign}, 32'd0);
        rd_m  = 32'd0;
        mis_m = 1'b0;
        @(negedge clk);
        clr();
        rst = 1'b0;
        @(posedge clk); #1;
        access(3'd3, 2'd0, 32'h20, 32'd0, 1'b0);
        chk("rst_no_commit", ReadData, prior);

        access(3'd3, 2'd0, 32'h22, 32'd0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_lw_rdata", ReadData, 32'd0);
        chk("mis_lw_flag", {31'd0, misalign}, 32'd1);
        access(3'd3, 2'd0, 32'h10, 32'd0, 1'b0);
        chk("mis_sticky", {31'd0, misalign}, 32'd1);
`else
        chk("mis_lw_rdata", ReadData, prior);
        chk("mis_lw_flag", {31'd0, misalign}, 32'd0);
`endif

        access(3'd0, 2'd3, 32'h400, 32'h1234_5678, 1'b0);
        access(3'd3, 2'd0, 32'h0, 32'd0, 1'b0);
        chk("wrap", ReadData, 32'h1234_5678);
        access(3'd3, 2'd3, 32'h30, 32'hCAFE_F00D, 1'b0);
        chk("both_rdata_held", ReadData, 32'h1234_5678);
        access(3'd3, 2'd0, 32'h30, 32'd0, 1'b0);
        chk("both_wrote", ReadData, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            r    = 3'($urandom_range(0, 7));
            wsel = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            access(r, wsel, $urandom, $urandom, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
